// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared state, opcode and mux-select encodings for the
//               multicycle RV32I controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
// ============================================================================
// Module      : alu_decoder
// Description : Maps ALUOp and the instruction funct fields to ALUControl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // op[5] separates R-type from I-type: addi never subtracts
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b100:  o_alu_control = ALU_XOR;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM sequencing a multicycle RV32I datapath.
//               Optional macro MEM_WAIT_EN adds mem_ready wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  state_t r_state;
  state_t w_next;
  aluop_t w_aluop;
  logic   w_mem_ok;
  logic   w_pcupdate, w_branch, w_irw, w_memw, w_regw, w_done, w_ill;

`ifdef MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok           = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pcupdate = 1'b0;
    w_branch   = 1'b0;
    w_irw      = 1'b0;
    w_memw     = 1'b0;
    w_regw     = 1'b0;
    w_done     = 1'b0;
    w_ill      = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_irw      = w_mem_ok;
        w_pcupdate = w_mem_ok;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        w_next     = w_mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default: begin
            w_ill  = 1'b1;
            w_done = 1'b1;
            w_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = w_mem_ok ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        w_regw    = 1'b1;
        w_done    = 1'b1;
      end
      S_MEMWRITE: begin
        // MemWrite stays high across the wait; completion only with the accept
        AdrSrc = 1'b1;
        w_memw = 1'b1;
        w_done = w_mem_ok;
        w_next = w_mem_ok ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_regw = 1'b1;
        w_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_RD2;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
        w_done   = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        w_pcupdate = 1'b1;
        w_next     = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_aluop       (w_aluop),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (ALUControl)
  );

  // Enables are gated by reset so nothing commits while reset is held low
  assign PCWrite       = reset & (w_pcupdate | (w_branch & Zero));
  assign IRWrite       = reset & w_irw;
  assign MemWrite      = reset & w_memw;
  assign RegWrite      = reset & w_regw;
  assign instr_done    = reset & w_done;
  assign illegal_instr = reset & w_ill;
  assign state_dbg     = STATE_W'(r_state);

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a multicycle RV32I datapath (shared instruction/data memory, IR/OldPC/ALUOut/Data registers) over several clocks per instruction.
- Replaces the single-cycle main decoder; drives all mux selects and write enables.
- Supports lw, sw, R-type, I-type ALU, beq and jal; other opcodes are flagged as illegal.

Parameters:
- OP_W, 7, opcode width.
- STATE_W, 4, state register width; 11 states used.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake; used only with MEM_WAIT_EN
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 const 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state_dbg  out  STATE_W  current state, for debug

Behaviour:
- Reset: clk and reset; reset is asynchronous and active-low. While reset=0, state=FETCH and PCWrite, IRWrite, MemWrite, RegWrite, instr_done and illegal_instr are forced to 0. The first FETCH executes on the first rising edge after reset goes high. Reset asserted mid-instruction aborts the instruction immediately; no partial write occurs after the reset edge.
- All outputs are combinational (Moore) from state. Exceptions: ImmSrc and ALUControl also depend on op/funct; PCWrite also depends on Zero.
- PCWrite = PCUpdate | (Branch & Zero).
- Per-state outputs (unlisted signals = 0):
  - FETCH: IRWrite, PCUpdate, ALUSrcB=10, ResultSrc=10, ALUOp=add. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (precomputes branch target). Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH with illegal_instr=1 and instr_done=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add. Next: MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD: AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite, instr_done. Next: FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite, instr_done. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Next: ALUWB.
  - ALUWB: RegWrite, ResultSrc=00, instr_done. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, Branch, ResultSrc=00, instr_done. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate. Next: ALUWB.
- ALU decode for ALUOp=funct, by funct3:
  - 000: sub if op[5]&funct7b5, else add
  - 010: slt
  - 100: xor
  - 110: or
  - 111: and
  - other: add
- ImmSrc from op: lw/I-type 00, sw 01, beq 10, jal 11; unknown op 00.
- Latency in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.
- Branch not taken (Zero=0 in BEQ): PCWrite=0; the PC already holds PC+4 from FETCH.
- Unknown encodings are never stuck: any unreachable state value returns to FETCH on the next edge.

Optional Feature:
- MEM_WAIT_EN defined: FETCH, MEMREAD and MEMWRITE hold state while mem_ready=0. While held, the write enables stay asserted but the registers see no commit: PCWrite/IRWrite are qualified by mem_ready, and MemWrite is held high. The state advances on the edge where mem_ready=1.
- MEM_WAIT_EN undefined: mem_ready is ignored and timing is exactly as above.

Decomposition:
- Package riscv_ctrl_pkg: state encoding constants, opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL), mux-select and ALUControl encodings.
- Sub-module alu_decoder: (ALUOp, funct3, funct7b5, op[5]) -> ALUControl, combinational.

Test Plan:
- Reset held low for 3 edges, op=0110011 -> state_dbg=FETCH, all enables 0; first edge after release enters DECODE with IRWrite=1 in the preceding FETCH cycle.
- op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1, ResultSrc=01 only in cycle 5; instr_done is a single pulse.
- op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; op=0010011, funct3=000, funct7b5=1 -> ALUControl=000 (addi, no sub).
- BEQ with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- op=1101111 -> JAL asserts PCWrite=1, ALUSrcA=01, ALUSrcB=10, then ALUWB with RegWrite=1; op=1111111 -> illegal_instr pulse in DECODE, then FETCH.
- MEM_WAIT_EN, sw with mem_ready low for 3 cycles in MEMWRITE -> state holds 3 cycles, MemWrite stays high, exits to FETCH on the edge where mem_ready=1; reset pulsed during the hold -> FETCH, MemWrite=0.
